// File: rtl/pending_encoder_pkg.sv
// pending_encoder_pkg: shared FSM encoding and default sizing for the pending encoder
package pending_encoder_pkg;
  localparam int N_DEF = 8;
  localparam int W_DEF = 3;
  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/pending_encoder_prio_enc.sv
// prio_enc: combinational lowest-index priority encoder with any-set flag
module prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? W'(i) : idx;
  end
  assign any = |req;
endmodule

// File: rtl/pending_encoder.sv
// pending_encoder: latches requests into a pending vector and grants them one at a time,
// lowest index first, holding each grant until acknowledged.
module pending_encoder
  import pending_encoder_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [N-1:0] in,
  input  logic         ack,
  output logic [W-1:0] out,
  output logic         valid,
  output logic [N-1:0] pending,
  output logic         overflow
);
  state_t state, state_n;
  logic [W-1:0] idx, out_n;
  logic any, take;
  logic [N-1:0] clr_mask, set_mask, pending_n;
  prio_enc #(.N(N), .W(W)) u_prio_enc (.req(pending), .idx(idx), .any(any));
  always_comb begin
    take = valid && ack;
    clr_mask = take ? {{(N-1){1'b0}}, 1'b1} << out : '0;
    set_mask = enable ? in : '0;
    pending_n = (pending & ~clr_mask) | set_mask;
    state_n = state == IDLE ? (any ? GRANT : IDLE) : (ack ? IDLE : GRANT);
    out_n = state == IDLE ? (any ? idx : '0) : (ack ? '0 : out);
  end
  // grant is chosen from the registered pending vector, which forces the post-ack bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pending <= '0;
      out <= '0;
      valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      pending <= pending_n;
      out <= out_n;
      valid <= state_n == GRANT;
      overflow <= |(set_mask & pending & ~clr_mask);
    end
  end
endmodule

// File: tb/tb_pending_encoder.sv
// tb_pending_encoder: directed and randomized checks of pending_encoder against a set-based model
module tb_pending_encoder;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, ack = 1'b0;
  logic [7:0] req = '0;
  logic [2:0] out;
  logic valid, overflow;
  logic [7:0] pending;
  int passed = 0, total = 0;
  bit m_pend[8];
  int m_grant = -1;
  bit m_ov = 0;
  int ov_count, waits;
  pending_encoder dut (.clk(clk), .rst(rst), .enable(enable), .in(req), .ack(ack),
                       .out(out), .valid(valid), .pending(pending), .overflow(overflow));
  always #5 clk = ~clk;
  function automatic int lowest();
    for (int i = 0; i < 8; i++) if (m_pend[i]) return i;
    return -1;
  endfunction
  function automatic logic [7:0] m_vec();
    logic [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic model(input logic e, input logic [7:0] r, input logic a, input logic rs);
    int cleared, first;
    if (rs) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_grant = -1;
      m_ov = 0;
      return;
    end
    cleared = (m_grant >= 0 && a) ? m_grant : -1;
    first = lowest();
    m_ov = 0;
    for (int i = 0; i < 8; i++) if (e && r[i] && m_pend[i] && i != cleared) m_ov = 1;
    if (m_grant < 0) m_grant = first;
    else if (a) m_grant = -1;
    for (int i = 0; i < 8; i++) m_pend[i] = (m_pend[i] && i != cleared) || (e && r[i]);
  endtask
  task automatic step(input logic e, input logic [7:0] r, input logic a, input logic rs = 1'b0);
    enable = e; req = r; ack = a; rst = rs;
    @(posedge clk);
    model(e, r, a, rs);
    #1;
    chk("valid", 32'(valid), 32'(m_grant >= 0));
    chk("out", 32'(out), m_grant >= 0 ? 32'(m_grant) : 32'd0);
    chk("pending", 32'(pending), 32'(m_vec()));
    chk("overflow", 32'(overflow), 32'(m_ov));
    if (overflow) ov_count++;
  endtask
  initial begin
    #1;
    step(0, 8'h00, 1, 1);
    chk("reset_pending", 32'(pending), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    step(1, 8'h20, 0);
    chk("single_pend", 32'(pending), 32'h20);
    chk("single_nvalid", 32'(valid), 32'h0);
    step(1, 8'h00, 0);
    chk("single_out", 32'(out), 32'd5);
    chk("single_valid", 32'(valid), 32'h1);
    step(1, 8'h00, 1);
    chk("single_clear", {24'h0, pending, 7'h0, valid}, 32'h0);
    step(1, 8'hFF, 0);
    for (int k = 0; k < 8; k++) begin
      waits = 0;
      while (!valid && waits < 4) begin step(1, 8'h00, 0); waits++; end
      chk("prio_gap", 32'(waits), 32'd1);
      chk("prio_out", 32'(out), 32'(k));
      step(1, 8'h00, 1);
    end
    chk("prio_empty", 32'(pending), 32'h0);
    step(1, 8'h10, 0);
    step(1, 8'h00, 0);
    step(1, 8'h01, 0);
    chk("hold_out", 32'(out), 32'd4);
    step(1, 8'h00, 0);
    chk("hold_out2", 32'(out), 32'd4);
    step(1, 8'h00, 1);
    step(1, 8'h00, 0);
    chk("hold_next", 32'(out), 32'd0);
    step(1, 8'h00, 1);
    step(1, 8'h00, 0);
    ov_count = 0;
    step(1, 8'h08, 0);
    step(1, 8'h00, 0);
    chk("coll_grant", 32'(out), 32'd3);
    step(1, 8'h08, 0);
    step(1, 8'h08, 1);
    chk("coll_keep", 32'(pending[3]), 32'h1);
    step(1, 8'h00, 0);
    chk("coll_regrant", 32'(out), 32'd3);
    chk("coll_ovcount", 32'(ov_count), 32'd1);
    step(1, 8'h00, 1);
    step(1, 8'h00, 0);
    ov_count = 0;
    step(0, 8'hFF, 0);
    step(0, 8'hFF, 1);
    chk("gate_pend", 32'(pending), 32'h0);
    chk("gate_ov", 32'(ov_count), 32'd0);
    step(1, 8'hFF, 0);
    step(1, 8'h00, 0);
    chk("gate_out", {28'h0, out, valid}, {28'h0, 3'd0, 1'b1});
    step(0, 8'h00, 0, 1);
    step(1, 8'h0C, 0);
    step(1, 8'h00, 0);
    chk("rst_pre", {24'h0, pending, 4'h0, out, valid}, {24'h0, 8'h0C, 4'h0, 3'd2, 1'b1});
    step(1, 8'h00, 1, 1);
    chk("rst_mid", {24'h0, pending, 4'h0, out, valid}, 32'h0);
    for (int k = 0; k < 3; k++) step(1, 8'h00, 0);
    chk("rst_nogrant", 32'(valid), 32'h0);
    for (int k = 0; k < 500; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0 ? 8'($urandom) : 8'h00,
           valid ? 1'($urandom_range(0, 1)) : $urandom_range(0, 4) == 0,
           $urandom_range(0, 59) == 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pending_encoder.md
PENDING_ENCODER -- requirements
Module: pending_encoder

Interface
REQ-001 Parameter N, default 8: number of request lines; SHALL be a power of two, 2..256.
REQ-002 Parameter W, default 3: index width; SHALL equal log2(N).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 enable  input  1  1 = accept new requests; 0 = ignore in[], in-flight grant continues.
REQ-006 in  input  N  request lines, level-sampled every cycle; bit i = request i.
REQ-007 ack  input  1  consumer accepts the current index; meaningful only while valid=1.
REQ-008 out  output  W  encoded index of the granted request.
REQ-009 valid  output  1  out holds a granted index.
REQ-010 pending  output  N  registered pending-request vector.
REQ-011 overflow  output  1  one-cycle pulse: a request hit an already-pending bit.

Function
REQ-012 Pending update each cycle: pending_next = (pending & ~clr_mask) | (enable ? in : 0); clr_mask = one-hot of out when valid && ack, else 0.
REQ-013 Set SHALL win over clear on the same bit in the same cycle; that bit stays pending.
REQ-014 overflow SHALL assert in cycle t+1 iff at cycle t enable=1 and (in & pending & ~clr_mask) != 0.
REQ-015 Priority: lowest set index wins; bit 0 is highest priority.
REQ-016 FSM states IDLE, GRANT; reset state IDLE.
REQ-017 IDLE: if pending != 0, register out = lowest set index of pending, valid = 1, go to GRANT; else stay, valid = 0.
REQ-018 GRANT: out and valid SHALL hold stable until ack=1, even if a higher-priority bit becomes pending.
REQ-019 GRANT with ack=1: clear pending[out], valid = 0 next cycle, go to IDLE.
REQ-020 Mandatory one-cycle bubble after every ack; the next grant can appear no earlier than 2 cycles after the ack cycle.
REQ-021 Latency: request sampled at edge t with FSM idle and pending empty -> pending bit set after edge t -> valid=1, out valid after edge t+1.
REQ-022 ack while valid=0 SHALL be ignored and have no effect.
REQ-023 enable=0 SHALL NOT clear pending or cancel the current grant; acks still clear bits.
REQ-024 All N bits requested simultaneously: grants SHALL issue in order 0,1,...,N-1, one per ack.
REQ-025 out SHALL be 0 whenever valid=0.

Reset
REQ-026 On rst=1 at a clock edge: pending = 0, out = 0, valid = 0, overflow = 0, FSM = IDLE.
REQ-027 rst SHALL override in/ack in the same cycle; reset mid-grant drops the grant with no ack required.
REQ-028 First grant after reset release SHALL follow REQ-021 timing exactly.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding (IDLE, GRANT) and defaults N=8, W=3.
REQ-030 One sub-module, prio_enc: combinational N-to-W lowest-index priority encoder with any-set flag; all registers stay in pending_encoder.

Verification
REQ-031 Single request: enable=1, in=8'b0010_0000 for one cycle -> pending=8'h20 after edge 0, valid=1 and out=5 after edge 1; ack -> pending=0, valid=0.
REQ-032 Priority: in=8'hFF for one cycle, ack each grant as it appears -> out sequence 0..7, each grant 2 cycles after the previous ack, pending=0 at end.
REQ-033 Hold: grant out=4 active, then in=8'h01 with ack=0 -> out stays 4 until ack; next grant out=0.
REQ-034 Collision: in=8'h08 held while out=3 is acked -> pending[3] stays 1, overflow pulses once, next grant out=3.
REQ-035 Gating: enable=0, in=8'hFF -> pending=0, valid=0, no overflow; then enable=1 -> valid=1, out=0 after 2 edges.
REQ-036 Reset mid-grant: valid=1, out=2, pending=8'h0C, assert rst one cycle -> pending=0, valid=0, out=0, no further grants.
